// File: rtl/fastram_burst_ctrl_if.sv
// fastram_burst_ctrl_if: 68030 bus and fast-RAM strobes of the fast-RAM controller.
//   master modport: CPU/bench side. Drives a, siz, rw20, as20, ds20, cbreq and cfg_done.
//   slave modport : controller side. Drives sterm, cback, ciin, intcycle, ramcs, ramoe,
//                   ramwe, rambe and rama.
// All strobes named after 68030/RAM pins keep their active-low sense (1 = negated).
interface fastram_burst_ctrl_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned BANKS  = 4
);
  logic [ADDR_W-1:0] a;
  logic [1:0]        siz;
  logic              rw20;
  logic              as20;
  logic              ds20;
  logic              cbreq;
  logic              cfg_done;
  logic              sterm;
  logic              cback;
  logic              ciin;
  logic              intcycle;
  logic [BANKS-1:0]  ramcs;
  logic              ramoe;
  logic              ramwe;
  logic [3:0]        rambe;
  logic [1:0]        rama;

  modport master (
    output a, siz, rw20, as20, ds20, cbreq, cfg_done,
    input  sterm, cback, ciin, intcycle, ramcs, ramoe, ramwe, rambe, rama
  );

  modport slave (
    input  a, siz, rw20, as20, ds20, cbreq, cfg_done,
    output sterm, cback, ciin, intcycle, ramcs, ramoe, ramwe, rambe, rama
  );
endinterface

// File: rtl/fastram_burst_ctrl.sv
// fastram_burst_ctrl: decodes 68030 cycles into the fast-RAM window, drives per-bank chip
// selects, OE/WE and byte lanes, and terminates with STERM after WAIT_STATES clocks.
// Honours 68030 cache-line bursts (CBREQ/CBACK, four beats, wrapping long-word index).
// Ports:
//   clkcpu_i - CPU clock, everything on the rising edge
//   reset_i  - synchronous active-high reset
//   bus_io   - fastram_burst_ctrl_if.slave: CPU inputs in, STERM/CBACK/CIIN/INTCYCLE and
//              RAM strobes/address out
module fastram_burst_ctrl #(
  parameter int unsigned                  ADDR_W      = 24,
  parameter int unsigned                  MATCH_LSB   = 21,
  parameter logic [ADDR_W-MATCH_LSB-1:0]  RAM_BASE    = 3'b001,
  parameter int unsigned                  BANKS       = 4,
  parameter int unsigned                  WAIT_STATES = 1,
  parameter bit                           BURST_EN    = 1'b1
) (
  input  logic               clkcpu_i,
  input  logic               reset_i,
  fastram_burst_ctrl_if.slave bus_io
);

  localparam int unsigned BankW  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [2:0]  WsInit = 3'(WAIT_STATES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StTerm = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  logic [1:0]       state_d, state_q;
  logic [2:0]       cnt_d, cnt_q;
  logic [1:0]       beat_d, beat_q;
  logic [1:0]       rama_d, rama_q;
  logic [BankW-1:0] bank_d, bank_q;
  logic             rw_d, rw_q;
  logic             burst_d, burst_q;
  logic [3:0]       be_d, be_q;

  logic             hit;
  logic [BankW-1:0] hit_bank;
  logic [3:0]       be_dec;
  logic [BANKS-1:0] cs_sel;
  logic             active;
  int               n_bytes;
  int               offset;

  assign hit = ~bus_io.as20 & bus_io.cfg_done &
               (bus_io.a[ADDR_W-1:MATCH_LSB] == RAM_BASE);

  if (BANKS > 1) begin : g_bank
    assign hit_bank = bus_io.a[MATCH_LSB-1 -: BankW];
  end else begin : g_one_bank
    assign hit_bank = '0;
  end

  // 68030 32-bit port lane table: the operand occupies bytes offset..offset+size-1 of the
  // long word, clipped at byte 3. Byte 0 (D31:24) is lane bit 3.
  always_comb begin
    be_dec  = 4'hF;
    offset  = int'(bus_io.a[1:0]);
    n_bytes = (bus_io.siz == 2'b00) ? 4 : int'(bus_io.siz);
    for (int i = 0; i < 4; i++) begin
      if (i >= offset && i < offset + n_bytes) begin
        be_dec[3-i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    rama_d  = rama_q;
    bank_d  = bank_q;
    rw_d    = rw_q;
    burst_d = burst_q;
    be_d    = be_q;
    case (state_q)
      StIdle: begin
        if (hit) begin
          bank_d  = hit_bank;
          rw_d    = bus_io.rw20;
          rama_d  = bus_io.a[3:2];
          burst_d = BURST_EN & ~bus_io.cbreq & bus_io.rw20;
          be_d    = be_dec;
          beat_d  = 2'd0;
          cnt_d   = WsInit;
          state_d = (WAIT_STATES == 0) ? StTerm : StWait;
        end
      end
      StWait: begin
        // A negated AS20 aborts before any STERM is issued.
        if (bus_io.as20) begin
          state_d = StIdle;
        end else if (cnt_q == 3'd0) begin
          state_d = StTerm;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StTerm: begin
        if (bus_io.as20) begin
          state_d = StIdle;
        end else if (burst_q && beat_q != 2'd3) begin
          // CBREQ is not rechecked: once acknowledged the line always completes.
          beat_d  = beat_q + 2'd1;
          rama_d  = rama_q + 2'd1;
          cnt_d   = WsInit;
          state_d = (WAIT_STATES == 0) ? StTerm : StWait;
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (bus_io.as20) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clkcpu_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
      rama_q  <= '0;
      bank_q  <= '0;
      rw_q    <= 1'b1;
      burst_q <= 1'b0;
      be_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      rama_q  <= rama_d;
      bank_q  <= bank_d;
      rw_q    <= rw_d;
      burst_q <= burst_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    cs_sel = '0;
    for (int unsigned i = 0; i < BANKS; i++) begin
      if (bank_q == BankW'(i)) begin
        cs_sel[i] = 1'b1;
      end
    end
  end

  assign active = (state_q == StWait) || (state_q == StTerm);

  assign bus_io.sterm    = ~(state_q == StTerm);
  assign bus_io.cback    = ~((state_q == StTerm) & burst_q & (beat_q == 2'd0));
  assign bus_io.ciin     = 1'b1;
  // Held through HOLD so the TF_OVR term stays overridden until AS20 negates.
  assign bus_io.intcycle = (state_q == StIdle);
  assign bus_io.ramcs    = active ? ~cs_sel : '1;
  assign bus_io.ramoe    = ~(active & rw_q);
  // DS20 qualifies the write strobe combinationally so WE tracks the data strobe exactly.
  assign bus_io.ramwe    = ~(active & ~rw_q & ~bus_io.ds20);
  assign bus_io.rambe    = active ? (rw_q ? 4'h0 : be_q) : 4'hF;
  assign bus_io.rama     = rama_q;

endmodule

// File: tb/tb_fastram_burst_ctrl.sv
// Bench for fastram_burst_ctrl. Three instances share one stimulus:
//   0: WAIT_STATES=1, burst enabled   1: WAIT_STATES=3   2: BURST_EN=0
module tb_fastram_burst_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [23:0] a;
  logic [1:0]  siz;
  logic        rw20, as20, ds20, cbreq, cfg_done;

  // {sterm, cback, ciin, intcycle, ramcs[3:0], ramoe, ramwe, rambe[3:0], rama[1:0]}
  wire [15:0] outs [3];

  localparam logic [13:0] IdleOuts = 14'h3FFF;

  typedef struct packed {
    logic [1:0] rama;
    logic       cback;
    logic [3:0] cs;
    logic [3:0] be;
  } beat_t;

  beat_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int nb_cback_low = 0;
  int nb_sterm = 0;

  fastram_burst_ctrl_if #(.ADDR_W(24), .BANKS(4)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].a        = a;
    assign bus[g].siz      = siz;
    assign bus[g].rw20     = rw20;
    assign bus[g].as20     = as20;
    assign bus[g].ds20     = ds20;
    assign bus[g].cbreq    = cbreq;
    assign bus[g].cfg_done = cfg_done;

    fastram_burst_ctrl #(
      .ADDR_W     (24),
      .MATCH_LSB  (21),
      .RAM_BASE   (3'b001),
      .BANKS      (4),
      .WAIT_STATES((g == 1) ? 3 : 1),
      .BURST_EN   (g != 2)
    ) u_dut (
      .clkcpu_i(clk),
      .reset_i (rst),
      .bus_io  (bus[g])
    );

    assign outs[g] = {bus[g].sterm, bus[g].cback, bus[g].ciin, bus[g].intcycle,
                      bus[g].ramcs, bus[g].ramoe, bus[g].ramwe, bus[g].rambe, bus[g].rama};
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (outs[2][14] === 1'b0) nb_cback_low++;
      if (outs[2][15] === 1'b0) nb_sterm++;
    end
  end

  task automatic idle_inputs();
    a = '0; siz = 2'b00; rw20 = 1'b1; as20 = 1'b1; ds20 = 1'b1; cbreq = 1'b1;
  endtask

  // Advance negedges until instance k shows STERM low or n reaches limit.
  task automatic wait_sterm(input int k, input int limit, inout int n);
    while (n < limit && outs[k][15] !== 1'b0) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (outs[k] !== {IdleOuts, 2'b00}) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got %h want %h", k, outs[k], {IdleOuts, 2'b00});
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int n;
    beat_t e;
    a = 24'h200010; rw20 = 1'b1; siz = 2'b00; as20 = 1'b0;
    exp_q.push_back('{rama: 2'b00, cback: 1'b1, cs: 4'b1110, be: 4'b0000});
    @(negedge clk);
    n_checks++;
    if (outs[0] !== {4'b1110, 4'b1110, 2'b01, 4'b0000, 2'b00}) begin
      n_fail++;
      $display("FAIL read_wait_state: got %h want %h", outs[0],
               {4'b1110, 4'b1110, 2'b01, 4'b0000, 2'b00});
    end
    cfg_done = 1'b0;  // falling mid-cycle must not disturb this cycle
    n = 1;
    wait_sterm(0, 20, n);
    n_checks++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL read_latency: got %0d want 3", n);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({outs[0][1:0], outs[0][14], outs[0][11:8], outs[0][5:2]} !== e || outs[0][7] !== 1'b0)
    begin
      n_fail++;
      $display("FAIL read_beat: got %h want %h", outs[0], e);
    end
    @(negedge clk);
    n_checks++;
    if (outs[0][15:2] !== {4'b1110, 4'hF, 2'b11, 4'hF}) begin
      n_fail++;
      $display("FAIL read_hold: got %h want %h", outs[0][15:2], {4'b1110, 4'hF, 2'b11, 4'hF});
    end
    as20 = 1'b1; cfg_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs[0][15:2] !== IdleOuts) begin
      n_fail++;
      $display("FAIL read_release: got %h want %h", outs[0][15:2], IdleOuts);
    end
  endtask

  task automatic test_burst_read();
    int n;
    int extra;
    int base_st;
    int base_cb;
    beat_t e;
    base_st = nb_sterm;
    base_cb = nb_cback_low;
    @(negedge clk);
    a = 24'h20000C; rw20 = 1'b1; siz = 2'b00; cbreq = 1'b0; as20 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{rama: 2'(3 + i), cback: (i == 0) ? 1'b0 : 1'b1, cs: 4'b1110,
                        be: 4'b0000});
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      n = 1;
      wait_sterm(0, 20, n);
      n_checks++;
      if (n !== 3) begin
        n_fail++;
        $display("FAIL burst_latency beat%0d: got %0d want 3", b, n);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({outs[0][1:0], outs[0][14], outs[0][11:8], outs[0][5:2]} !== e) begin
          n_fail++;
          $display("FAIL burst_beat%0d: got %h want %h", b,
                   {outs[0][1:0], outs[0][14], outs[0][11:8], outs[0][5:2]}, e);
        end
      end
      cbreq = 1'b1;  // negated mid-burst, must be ignored
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (outs[0][15] !== 1'b1 || outs[0][12] !== 1'b0) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL burst_extra_beats: got %0d bad cycles want 0", extra);
    end
    n_checks++;
    if (nb_sterm - base_st !== 1 || nb_cback_low - base_cb !== 0) begin
      n_fail++;
      $display("FAIL burst_disabled_single: got %0d sterm %0d cback want 1 sterm 0 cback",
               nb_sterm - base_st, nb_cback_low - base_cb);
    end
    as20 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs[0][15:2] !== IdleOuts) begin
      n_fail++;
      $display("FAIL burst_release: got %h want %h", outs[0][15:2], IdleOuts);
    end
  endtask

  task automatic test_byte_write();
    int n;
    beat_t e;
    @(negedge clk);
    a = 24'h200001; siz = 2'b01; rw20 = 1'b0; ds20 = 1'b1; as20 = 1'b0;
    exp_q.push_back('{rama: 2'b00, cback: 1'b1, cs: 4'b1110, be: 4'b1011});
    @(negedge clk);
    n_checks++;
    if (outs[0] !== {4'b1110, 4'b1110, 2'b11, 4'b1011, 2'b00}) begin
      n_fail++;
      $display("FAIL write_wait_ds_high: got %h want %h", outs[0],
               {4'b1110, 4'b1110, 2'b11, 4'b1011, 2'b00});
    end
    ds20 = 1'b0;
    #1;
    n_checks++;
    if (outs[0][6] !== 1'b0) begin
      n_fail++;
      $display("FAIL write_we_ds_low: got %b want 0", outs[0][6]);
    end
    n = 1;
    wait_sterm(0, 20, n);
    n_checks++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL write_latency: got %0d want 3", n);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({outs[0][1:0], outs[0][14], outs[0][11:8], outs[0][5:2]} !== e ||
        outs[0][7:6] !== 2'b10) begin
      n_fail++;
      $display("FAIL write_beat: got %h want %h", outs[0], e);
    end
    @(negedge clk);
    n_checks++;
    if (outs[0][15:2] !== {4'b1110, 4'hF, 2'b11, 4'hF}) begin
      n_fail++;
      $display("FAIL write_hold: got %h want %h", outs[0][15:2], {4'b1110, 4'hF, 2'b11, 4'hF});
    end
    as20 = 1'b1; ds20 = 1'b1; rw20 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lanes();
    logic [23:0] ta [6];
    logic [1:0]  ts [6];
    logic [7:0]  te [6];
    ta = '{24'h200002, 24'h280001, 24'h300000, 24'h380002, 24'h200003, 24'h300000};
    ts = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00};
    te = '{8'b1110_1100, 8'b1101_1001, 8'b1011_0001, 8'b0111_1100, 8'b1110_1110,
           8'b1011_0000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = ta[i]; siz = ts[i]; rw20 = 1'b0; ds20 = 1'b1; as20 = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({outs[0][11:8], outs[0][5:2]} !== te[i]) begin
        n_fail++;
        $display("FAIL lanes%0d: got %b want %b", i, {outs[0][11:8], outs[0][5:2]}, te[i]);
      end
      as20 = 1'b1;
      @(negedge clk);
      n_checks++;
      if (outs[0][15:2] !== IdleOuts) begin
        n_fail++;
        $display("FAIL lanes_abort%0d: got %h want %h", i, outs[0][15:2], IdleOuts);
      end
    end
    rw20 = 1'b1;
  endtask

  task automatic test_no_hit();
    int bad;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      cfg_done = (c == 1); a = (c == 0) ? 24'h200010 : 24'hF80000; rw20 = 1'b1;
      as20 = 1'b0;
      bad = 0;
      repeat (6) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (outs[k][11:8] !== 4'hF || outs[k][15] !== 1'b1 || outs[k][12] !== 1'b1) bad++;
        end
      end
      n_checks++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL no_hit%0d: got %0d active samples want 0", c, bad);
      end
      as20 = 1'b1; cfg_done = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int n;
    int bad;
    beat_t e;
    @(negedge clk);
    a = 24'h200010; rw20 = 1'b1; siz = 2'b00; as20 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs[1][15:2] !== {4'b1110, 4'b1110, 2'b01, 4'b0000}) begin
      n_fail++;
      $display("FAIL abort_wait: got %h want %h", outs[1][15:2],
               {4'b1110, 4'b1110, 2'b01, 4'b0000});
    end
    @(negedge clk);
    as20 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs[1][15:2] !== IdleOuts) begin
      n_fail++;
      $display("FAIL abort_idle: got %h want %h", outs[1][15:2], IdleOuts);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (outs[1][15] !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL abort_no_sterm: got %0d sterm cycles want 0", bad);
    end
    as20 = 1'b0;
    exp_q.push_back('{rama: 2'b00, cback: 1'b1, cs: 4'b1110, be: 4'b0000});
    @(negedge clk);
    n = 1;
    wait_sterm(1, 20, n);
    n_checks++;
    if (n !== 5) begin
      n_fail++;
      $display("FAIL ws3_latency: got %0d want 5", n);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({outs[1][1:0], outs[1][14], outs[1][11:8], outs[1][5:2]} !== e) begin
      n_fail++;
      $display("FAIL ws3_beat: got %h want %h",
               {outs[1][1:0], outs[1][14], outs[1][11:8], outs[1][5:2]}, e);
    end
    @(negedge clk);
    as20 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    beat_t e;
    @(negedge clk);
    a = 24'h200004; rw20 = 1'b1; siz = 2'b00; cbreq = 1'b0; as20 = 1'b0;
    exp_q.push_back('{rama: 2'b01, cback: 1'b0, cs: 4'b1110, be: 4'b0000});
    @(negedge clk);
    n = 1;
    wait_sterm(0, 20, n);
    e = exp_q.pop_front();
    n_checks++;
    if (n !== 3 || {outs[0][1:0], outs[0][14], outs[0][11:8], outs[0][5:2]} !== e) begin
      n_fail++;
      $display("FAIL rst_burst_beat1: got %0d clks %h want 3 clks %h", n,
               {outs[0][1:0], outs[0][14], outs[0][11:8], outs[0][5:2]}, e);
    end
    cbreq = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (outs[k] !== {IdleOuts, 2'b00}) begin
        n_fail++;
        $display("FAIL rst_mid_burst dut%0d: got %h want %h", k, outs[k], {IdleOuts, 2'b00});
      end
    end
    as20 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst_disabled();
    n_checks++;
    if (nb_cback_low !== 0) begin
      n_fail++;
      $display("FAIL burst_en0_cback: got %0d low cycles want 0", nb_cback_low);
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_done = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_burst_read();
    test_byte_write();
    test_lanes();
    test_no_hit();
    test_abort();
    test_reset_mid_burst();
    test_burst_disabled();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
